uart_frame_decoder: RTL and testbench

Consumes the byte stream produced by the UART receiver (one-cycle `iValid` strobe with `iData`) and parses it into framed memory-write commands. Payload bytes are buffered until the frame checksum verifies. Only then are they replayed as a valid/ready write stream into the system bus bridge. Bad, oversized, or stalled frames are discarded whole and counted.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_frame_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame decoder: protocol bytes and parser state encodings.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef logic [2:0] frameStateT;

    localparam frameStateT ST_IDLE    = 3'd0;
    localparam frameStateT ST_CMD     = 3'd1;
    localparam frameStateT ST_ADDR_LO = 3'd2;
    localparam frameStateT ST_ADDR_HI = 3'd3;
    localparam frameStateT ST_LEN     = 3'd4;
    localparam frameStateT ST_PAYLOAD = 3'd5;
    localparam frameStateT ST_CSUM    = 3'd6;
    localparam frameStateT ST_COMMIT  = 3'd7;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one synchronous write port, one combinational read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          iClk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge iClk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses framed write commands from a UART byte stream, verifies the checksum, then
// replays the buffered payload as a valid/ready write stream.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ       = 25000000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 1000,
    parameter int MAX_LEN        = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [7:0]  iData,
    input  logic        iValid,
    output logic [15:0] oWrAddr,
    output logic [7:0]  oWrData,
    output logic        oWrValid,
    input  logic        iWrReady,
    output logic        oFrameOk,
    output logic        oFrameErr,
    output logic [7:0]  oErrCount,
    output logic        oBusy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frameStateT    state;
    frameStateT    nextState;
    logic [TW-1:0] timeoutCount;
    logic [7:0]    sum;
    logic [7:0]    sumNext;
    logic [15:0]   frameAddr;
    logic [IW-1:0] frameLen;
    logic [IW-1:0] idx;
    logic          inFrame;
    logic          timedOut;
    logic          handshake;
    logic          lastWrite;
    logic          errEvent;
    logic          okEvent;
    logic          storeByte;
    logic          startCommit;
    logic          overrun;
    logic [AW-1:0] rdAddr;
    logic [7:0]    rdData;

    assign sumNext   = sum + iData;
    assign inFrame   = (state != ST_IDLE) && (state != ST_COMMIT);
    assign timedOut  = inFrame && !iValid && (timeoutCount == TW'(TIMEOUT_CYCLES - 1));
    assign handshake = oWrValid && iWrReady;
    assign lastWrite = (idx == frameLen - IW'(1));
    // During COMMIT the read port looks one entry ahead so the next byte is ready at the handshake.
    assign rdAddr    = (state == ST_COMMIT) ? AW'(idx + IW'(1)) : '0;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) uBuf (
        .iClk   (iClk),
        .wrEn   (storeByte),
        .wrAddr (AW'(idx)),
        .wrData (iData),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    always_comb begin
        nextState   = state;
        errEvent    = 1'b0;
        okEvent     = 1'b0;
        storeByte   = 1'b0;
        startCommit = 1'b0;
        overrun     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iValid && (iData == SYNC_BYTE)) nextState = ST_CMD;
            end
            ST_CMD: begin
                if (iValid) begin
                    if (iData == CMD_WRITE) begin
                        nextState = ST_ADDR_LO;
                    end else begin
                        nextState = ST_IDLE;
                        errEvent  = 1'b1;
                    end
                end
            end
            ST_ADDR_LO: begin
                if (iValid) nextState = ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
                if (iValid) nextState = ST_LEN;
            end
            ST_LEN: begin
                if (iValid) begin
                    if (iData == 8'd0) begin
                        nextState = ST_CSUM;
                    end else if (iData > 8'(MAX_LEN)) begin
                        nextState = ST_IDLE;
                        errEvent  = 1'b1;
                    end else begin
                        nextState = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (iValid) begin
                    storeByte = 1'b1;
                    if (lastWrite) nextState = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (iValid) begin
                    if (sumNext != 8'd0) begin
                        nextState = ST_IDLE;
                        errEvent  = 1'b1;
                    end else if (frameLen == '0) begin
                        nextState = ST_IDLE;
                        okEvent   = 1'b1;
                    end else begin
                        nextState   = ST_COMMIT;
                        startCommit = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                overrun = iValid;
                if (handshake && lastWrite) begin
                    nextState = ST_IDLE;
                    okEvent   = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
        if (timedOut) begin
            nextState = ST_IDLE;
            errEvent  = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= ST_IDLE;
            timeoutCount <= '0;
            sum          <= '0;
            frameAddr    <= '0;
            frameLen     <= '0;
            idx          <= '0;
            oWrAddr      <= '0;
            oWrData      <= '0;
            oWrValid     <= 1'b0;
            oFrameOk     <= 1'b0;
            oFrameErr    <= 1'b0;
            oErrCount    <= '0;
            oBusy        <= 1'b0;
        end else begin
            state     <= nextState;
            oBusy     <= (nextState != ST_IDLE);
            oFrameOk  <= okEvent;
            oFrameErr <= errEvent;

            if ((errEvent || overrun) && (oErrCount != 8'hFF)) begin
                oErrCount <= oErrCount + 8'd1;
            end

            if (iValid || !inFrame) begin
                timeoutCount <= '0;
            end else begin
                timeoutCount <= timeoutCount + TW'(1);
            end

            if ((state == ST_IDLE) && iValid && (iData == SYNC_BYTE)) begin
                sum <= 8'd0;
            end else if (inFrame && iValid) begin
                sum <= sumNext;
            end

            if (iValid && (state == ST_ADDR_LO)) frameAddr[7:0]  <= iData;
            if (iValid && (state == ST_ADDR_HI)) frameAddr[15:8] <= iData;
            if (iValid && (state == ST_LEN)) begin
                frameLen <= IW'(iData);
                idx      <= '0;
            end
            if (storeByte) idx <= idx + IW'(1);

            // Each accepted write advances to the prefetched next entry unless it was the last.
            if (startCommit) begin
                idx      <= '0;
                oWrValid <= 1'b1;
                oWrAddr  <= frameAddr;
                oWrData  <= rdData;
            end else if ((state == ST_COMMIT) && handshake) begin
                if (lastWrite) begin
                    oWrValid <= 1'b0;
                end else begin
                    idx     <= idx + IW'(1);
                    oWrAddr <= oWrAddr + 16'd1;
                    oWrData <= rdData;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: expected writes are queued as frames are sent
// and popped by a monitor on every accepted write.
module tb_uart_frame_decoder;

    localparam int TIMEOUT = 50;

    logic        iClk     = 1'b0;
    logic        iRst     = 1'b1;
    logic [7:0]  iData    = 8'h00;
    logic        iValid   = 1'b0;
    logic        iWrReady = 1'b0;
    logic [15:0] oWrAddr;
    logic [7:0]  oWrData;
    logic        oWrValid;
    logic        oFrameOk;
    logic        oFrameErr;
    logic [7:0]  oErrCount;
    logic        oBusy;

    uart_frame_decoder #(
        .CLK_FREQ       (50000),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_LEN        (16)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iData     (iData),
        .iValid    (iValid),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oWrValid  (oWrValid),
        .iWrReady  (iWrReady),
        .oFrameOk  (oFrameOk),
        .oFrameErr (oFrameErr),
        .oErrCount (oErrCount),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wrT;

    wrT          expQ[$];
    wrT          expWr;
    int          compareCount  = 0;
    int          mismatchCount = 0;
    int          okPulses      = 0;
    int          errPulses     = 0;
    logic        prevStall     = 1'b0;
    logic [15:0] prevAddr      = 16'h0;
    logic [7:0]  prevData      = 8'h0;

    // Monitor: counts pulses, checks stalled writes hold steady, and scores accepted writes.
    always @(negedge iClk) begin
        if (oFrameOk === 1'b1) okPulses++;
        if (oFrameErr === 1'b1) errPulses++;
        if (prevStall && (oWrValid === 1'b1)) begin
            compareCount++;
            if ({oWrAddr, oWrData} !== {prevAddr, prevData}) begin
                mismatchCount++;
                $display("[TB] FAIL stall_hold: got %h/%h expected %h/%h", oWrAddr, oWrData, prevAddr, prevData);
            end
        end
        if ((oWrValid === 1'b1) && (iWrReady === 1'b1)) begin
            compareCount++;
            if (expQ.size() == 0) begin
                mismatchCount++;
                $display("[TB] FAIL write_unexpected: got %h/%h expected no write", oWrAddr, oWrData);
            end else begin
                expWr = expQ.pop_front();
                if ({oWrAddr, oWrData} !== {expWr.addr, expWr.data}) begin
                    mismatchCount++;
                    $display("[TB] FAIL write_data: got %h/%h expected %h/%h", oWrAddr, oWrData, expWr.addr, expWr.data);
                end
            end
        end
        prevStall = (oWrValid === 1'b1) && (iWrReady !== 1'b1);
        prevAddr  = oWrAddr;
        prevData  = oWrData;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        iData  = b;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        iData  = 8'h00;
    endtask

    // Payload byte i is seed*(i+1); writes are queued only for frames expected to commit.
    task automatic sendFrame(input logic [15:0] addr, input int len, input logic [7:0] seed,
                             input logic [7:0] csumAdj);
        logic [7:0] s;
        logic [7:0] d;
        wrT         w;
        s = 8'h01 + addr[7:0] + addr[15:8] + 8'(len);
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(addr[7:0]);
        sendByte(addr[15:8]);
        sendByte(8'(len));
        for (int i = 0; i < len; i++) begin
            d = 8'(seed * (i + 1));
            s = s + d;
            if (csumAdj == 8'h00) begin
                w.addr = addr + 16'(i);
                w.data = d;
                expQ.push_back(w);
            end
            sendByte(d);
        end
        sendByte(8'(8'h00 - s) + csumAdj);
    endtask

    task automatic waitFrameOk(input int bound, output int cycles);
        cycles = 0;
        while ((cycles < bound) && (oFrameOk !== 1'b1)) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        tick();
        tick();
        compareCount++;
        if ({oWrValid, oFrameOk, oFrameErr, oBusy, oErrCount, oWrAddr, oWrData} !== 36'h0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_outputs: got %b%b%b%b %h %h %h expected all zero",
                     oWrValid, oFrameOk, oFrameErr, oBusy, oErrCount, oWrAddr, oWrData);
        end
        iRst = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        int okBefore;
        okBefore = okPulses;
        iWrReady = 1'b1;
        sendFrame(16'h1000, 3, 8'h11, 8'h00);
        compareCount++;
        if ({oWrValid, oWrAddr, oWrData} !== {1'b1, 16'h1000, 8'h11}) begin
            mismatchCount++;
            $display("[TB] FAIL good_first_write: got %b %h %h expected 1 1000 11", oWrValid, oWrAddr, oWrData);
        end
        tick();
        tick();
        tick();
        compareCount++;
        if ({oFrameOk, oWrValid, oBusy} !== 3'b100) begin
            mismatchCount++;
            $display("[TB] FAIL good_complete: got ok/valid/busy=%b%b%b expected 100", oFrameOk, oWrValid, oBusy);
        end
        tick();
        compareCount++;
        if ((okPulses - okBefore) != 1 || oErrCount !== 8'd0 || expQ.size() != 0) begin
            mismatchCount++;
            $display("[TB] FAIL good_summary: got ok=%0d err=%0d pending=%0d expected 1 0 0",
                     okPulses - okBefore, oErrCount, expQ.size());
        end
    endtask

    task automatic test_bad_checksum();
        int errBefore;
        int okBefore;
        int cyc;
        errBefore = errPulses;
        sendFrame(16'h1000, 3, 8'h11, 8'h01);
        compareCount++;
        if ({oFrameErr, oWrValid, oBusy} !== 3'b100) begin
            mismatchCount++;
            $display("[TB] FAIL badsum_err: got err/valid/busy=%b%b%b expected 100", oFrameErr, oWrValid, oBusy);
        end
        tick();
        tick();
        compareCount++;
        if (oErrCount !== 8'd1 || (errPulses - errBefore) != 1) begin
            mismatchCount++;
            $display("[TB] FAIL badsum_count: got count=%0d pulses=%0d expected 1 1", oErrCount, errPulses - errBefore);
        end
        okBefore = okPulses;
        sendFrame(16'h2000, 2, 8'hAA, 8'h00);
        waitFrameOk(10, cyc);
        compareCount++;
        if (cyc != 2) begin
            mismatchCount++;
            $display("[TB] FAIL followup_latency: got %0d cycles expected 2", cyc);
        end
        tick();
        compareCount++;
        if ((okPulses - okBefore) != 1 || expQ.size() != 0 || oErrCount !== 8'd1) begin
            mismatchCount++;
            $display("[TB] FAIL followup_commit: got ok=%0d pending=%0d count=%0d expected 1 0 1",
                     okPulses - okBefore, expQ.size(), oErrCount);
        end
    endtask

    task automatic test_oversize_bad_cmd();
        int errBefore;
        errBefore = errPulses;
        sendByte(8'h00);
        sendByte(8'hFF);
        tick();
        compareCount++;
        if ((errPulses - errBefore) != 0 || oBusy !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL garbage_ignored: got pulses=%0d busy=%b expected 0 0", errPulses - errBefore, oBusy);
        end
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h10);
        sendByte(8'd17);
        compareCount++;
        if ({oFrameErr, oBusy} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL oversize_err: got err/busy=%b%b expected 10", oFrameErr, oBusy);
        end
        sendByte(8'hA5);
        sendByte(8'h02);
        compareCount++;
        if ({oFrameErr, oBusy} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL badcmd_err: got err/busy=%b%b expected 10", oFrameErr, oBusy);
        end
        tick();
        compareCount++;
        if (oErrCount !== 8'd3) begin
            mismatchCount++;
            $display("[TB] FAIL err_count_3: got %0d expected 3", oErrCount);
        end
    endtask

    task automatic test_backpressure_wrap();
        int         errBefore;
        int         okBefore;
        int         cyc;
        logic [7:0] countBefore;
        errBefore   = errPulses;
        okBefore    = okPulses;
        countBefore = oErrCount;
        iWrReady    = 1'b0;
        sendFrame(16'hFFFF, 2, 8'h5A, 8'h00);
        compareCount++;
        if ({oWrValid, oWrAddr, oWrData} !== {1'b1, 16'hFFFF, 8'h5A}) begin
            mismatchCount++;
            $display("[TB] FAIL wrap_first_write: got %b %h %h expected 1 ffff 5a", oWrValid, oWrAddr, oWrData);
        end
        tick();
        tick();
        sendByte(8'h77);
        tick();
        cyc = 0;
        while ((cyc < 20) && (oFrameOk !== 1'b1)) begin
            iWrReady = ~iWrReady;
            tick();
            cyc++;
        end
        compareCount++;
        if (oFrameOk !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL wrap_commit_done: got ok=%b after %0d cycles expected 1", oFrameOk, cyc);
        end
        iWrReady = 1'b1;
        tick();
        compareCount++;
        if (oErrCount !== countBefore + 8'd1 || (errPulses - errBefore) != 0) begin
            mismatchCount++;
            $display("[TB] FAIL overrun_count: got count=%0d pulses=%0d expected %0d 0",
                     oErrCount, errPulses - errBefore, countBefore + 8'd1);
        end
        compareCount++;
        if ((okPulses - okBefore) != 1 || expQ.size() != 0) begin
            mismatchCount++;
            $display("[TB] FAIL wrap_summary: got ok=%0d pending=%0d expected 1 0", okPulses - okBefore, expQ.size());
        end
    endtask

    task automatic test_timeout();
        int         cyc;
        logic [7:0] countBefore;
        countBefore = oErrCount;
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h10);
        cyc = 0;
        while ((cyc < TIMEOUT + 10) && (oFrameErr !== 1'b1)) begin
            tick();
            cyc++;
        end
        compareCount++;
        if (cyc != TIMEOUT) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_cycles: got %0d expected %0d", cyc, TIMEOUT);
        end
        compareCount++;
        if (oBusy !== 1'b0 || oErrCount !== countBefore + 8'd1) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_idle: got busy=%b count=%0d expected 0 %0d", oBusy, oErrCount, countBefore + 8'd1);
        end
        tick();
    endtask

    task automatic test_reset_mid_commit();
        int cyc;
        iWrReady = 1'b0;
        sendFrame(16'h3000, 3, 8'h21, 8'h00);
        compareCount++;
        if (oWrValid !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL rst_commit_active: got valid=%b expected 1", oWrValid);
        end
        expQ.delete();
        iRst = 1'b1;
        tick();
        compareCount++;
        if ({oWrValid, oFrameOk, oFrameErr, oBusy, oErrCount, oWrAddr, oWrData} !== 36'h0) begin
            mismatchCount++;
            $display("[TB] FAIL rst_mid_commit: got %b%b%b%b %h %h %h expected all zero",
                     oWrValid, oFrameOk, oFrameErr, oBusy, oErrCount, oWrAddr, oWrData);
        end
        iRst     = 1'b0;
        iWrReady = 1'b1;
        tick();
        sendFrame(16'h4000, 1, 8'h99, 8'h00);
        waitFrameOk(10, cyc);
        compareCount++;
        if (cyc != 1) begin
            mismatchCount++;
            $display("[TB] FAIL recovery_latency: got %0d cycles expected 1", cyc);
        end
        tick();
        compareCount++;
        if (expQ.size() != 0 || oErrCount !== 8'd0) begin
            mismatchCount++;
            $display("[TB] FAIL recovery_summary: got pending=%0d count=%0d expected 0 0", expQ.size(), oErrCount);
        end
    endtask

    initial begin
        $display("[TB] starting uart_frame_decoder bench");
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_oversize_bad_cmd();
        test_backpressure_wrap();
        test_timeout();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
